// File: rtl/sprite_blitter_if.sv
// Command, sprite-ROM and frame-buffer signals of the sprite blitter.
// A command transfers on a rising Clk edge where cmd_valid and cmd_ready are both 1;
// cmd_ready is high only while the blitter is idle, and cmd_valid while busy is dropped.
interface sprite_blitter_if #(
    parameter int SPR_ID_W = 4,
    parameter int PIX_W    = 10
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_clear;
    logic [10:0]                 cmd_x;
    logic [10:0]                 cmd_y;
    logic [SPR_ID_W-1:0]         cmd_sprite_id;
    logic [7:0]                  cmd_color;
    logic                        busy;
    logic                        done;
    logic [SPR_ID_W+PIX_W-1:0]   spr_rom_addr;
    logic [7:0]                  spr_rom_data;
    logic [7:0]                  fb_data;
    logic [18:0]                 fb_wraddress;
    logic                        fb_we;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_sprite_id, cmd_color, spr_rom_data,
        input  cmd_ready, busy, done, spr_rom_addr, fb_data, fb_wraddress, fb_we
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_sprite_id, cmd_color, spr_rom_data,
        output cmd_ready, busy, done, spr_rom_addr, fb_data, fb_wraddress, fb_we
    );
endinterface

// File: rtl/sprite_blitter.sv
// Frame-buffer writer: CLEAR fills the screen with one colour, BLIT copies a sprite
// from ROM with screen clipping and a transparent colour key.
module sprite_blitter #(
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter int         SPR_W       = 32,
    parameter int         SPR_H       = 32,
    parameter int         SPR_ID_W    = 4,
    parameter logic [7:0] TRANSPARENT = 8'hE3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    sprite_blitter_if.slave  bus,
    output logic [1:0]       dbg_state
);
    localparam int PIX_W = $clog2(SPR_W * SPR_H);
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = PIX_W - COL_W;

    localparam logic [18:0]        LAST_ADDR = 19'(SCREEN_W * SCREEN_H - 1);
    localparam logic [PIX_W-1:0]   LAST_PIX  = PIX_W'(SPR_W * SPR_H - 1);
    localparam logic [PIX_W-1:0]   ONE_PIX   = PIX_W'(1);
    localparam logic signed [11:0] X_MAX     = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX     = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_BLIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state;
    logic [10:0]           x_q;
    logic [10:0]           y_q;
    logic [SPR_ID_W-1:0]   id_q;
    logic [PIX_W-1:0]      idx;
    logic [PIX_W-1:0]      p2;
    logic                  v2;
    logic                  tail;

    // p2 is the pixel whose ROM byte is on spr_rom_data this cycle.
    logic [COL_W-1:0]      c2;
    logic [ROW_W-1:0]      r2;
    logic signed [11:0]    sx;
    logic signed [11:0]    sy;
    logic                  on_screen;
    logic                  pix_write;
    logic [18:0]           pix_addr;

    assign c2 = p2[COL_W-1:0];
    assign r2 = p2[PIX_W-1:COL_W];
    assign sx = $signed({x_q[10], x_q}) + $signed({{(12-COL_W){1'b0}}, c2});
    assign sy = $signed({y_q[10], y_q}) + $signed({{(12-ROW_W){1'b0}}, r2});
    assign on_screen = (sx >= 12'sd0) && (sx <= X_MAX) && (sy >= 12'sd0) && (sy <= Y_MAX);
    assign pix_write = v2 && (bus.spr_rom_data != TRANSPARENT) && on_screen;
    // Constant multiply by 640 reduces to (sy<<9)+(sy<<7); only used when on_screen.
    assign pix_addr  = 19'(sy) * 19'(SCREEN_W) + 19'(sx);

    assign dbg_state = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            bus.cmd_ready    <= 1'b1;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.fb_we        <= 1'b0;
            bus.fb_data      <= 8'd0;
            bus.fb_wraddress <= 19'd0;
            bus.spr_rom_addr <= '0;
            x_q              <= 11'd0;
            y_q              <= 11'd0;
            id_q             <= '0;
            idx              <= '0;
            p2               <= '0;
            v2               <= 1'b0;
            tail             <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.fb_we <= 1'b0;
                    v2        <= 1'b0;
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        x_q           <= bus.cmd_x;
                        y_q           <= bus.cmd_y;
                        id_q          <= bus.cmd_sprite_id;
                        if (bus.cmd_clear) begin
                            state            <= S_CLEAR;
                            bus.fb_we        <= 1'b1;
                            bus.fb_wraddress <= 19'd0;
                            bus.fb_data      <= bus.cmd_color;
                        end else begin
                            state            <= S_BLIT;
                            idx              <= '0;
                            bus.spr_rom_addr <= {bus.cmd_sprite_id, {PIX_W{1'b0}}};
                        end
                    end
                end
                S_CLEAR: begin
                    if (bus.fb_wraddress == LAST_ADDR) begin
                        state         <= S_IDLE;
                        bus.fb_we     <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else begin
                        bus.fb_wraddress <= bus.fb_wraddress + 19'd1;
                    end
                end
                S_BLIT: begin
                    v2        <= 1'b1;
                    p2        <= idx;
                    bus.fb_we <= pix_write;
                    if (pix_write) begin
                        bus.fb_wraddress <= pix_addr;
                        bus.fb_data      <= bus.spr_rom_data;
                    end
                    if (idx == LAST_PIX) begin
                        state <= S_DRAIN;
                        tail  <= 1'b0;
                    end else begin
                        idx              <= idx + ONE_PIX;
                        bus.spr_rom_addr <= {id_q, idx + ONE_PIX};
                    end
                end
                S_DRAIN: begin
                    // Two cycles: last ROM byte arrives, then its write is presented.
                    v2        <= 1'b0;
                    tail      <= 1'b1;
                    bus.fb_we <= pix_write;
                    if (pix_write) begin
                        bus.fb_wraddress <= pix_addr;
                        bus.fb_data      <= bus.spr_rom_data;
                    end
                    if (tail) begin
                        state         <= S_IDLE;
                        bus.done      <= 1'b1;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a per-cycle expectation stream built from the drawing rules,
// one compare process on the falling edge, plus literal pins on counts and addresses.
module tb_sprite_blitter;
    localparam int         N  = 1024;
    localparam logic [7:0] E3 = 8'hE3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [1:0] dbg_state;
    logic [1:0] sdbg_state;

    sprite_blitter_if bus ();
    sprite_blitter_if sbus ();

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    sprite_blitter #(.SCREEN_H(4)) sdut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .bus       (sbus),
        .dbg_state (sdbg_state)
    );

    always #5 Clk = ~Clk;

    logic [7:0] rom [0:16383];
    always @(posedge Clk) begin
        bus.spr_rom_data  <= rom[bus.spr_rom_addr];
        sbus.spr_rom_data <= rom[sbus.spr_rom_addr];
    end

    typedef struct packed {
        logic        we;
        logic [18:0] addr;
        logic [7:0]  data;
        logic        rom_v;
        logic [13:0] rom_addr;
        logic        done;
        logic        first;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int st_wr[$], st_fa[$], st_la[$], st_done[$], st_r0[$], st_rn[$], st_e3[$];
    int g_wr, g_fa, g_la, g_done, g_r0, g_rn, g_e3;

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Expected stream for a BLIT: issue in cycles 1..N, writes in 3..N+2, done in N+3.
    function automatic void push_blit(input int id, input int x, input int y);
        exp_t e;
        int p, c, r, px, py;
        logic [7:0] v;
        for (int k = 1; k <= N + 3; k++) begin
            e = '0;
            e.first = (k == 1);
            e.done  = (k == N + 3);
            if (k <= N) begin
                e.rom_v    = 1'b1;
                e.rom_addr = 14'(id * N + k - 1);
            end
            if (k >= 3 && k <= N + 2) begin
                p  = k - 3;
                c  = p % 32;
                r  = p / 32;
                px = x + c;
                py = y + r;
                v  = rom[id * N + p];
                if (v != E3 && px >= 0 && px < 640 && py >= 0 && py < 480) begin
                    e.we   = 1'b1;
                    e.addr = 19'(py * 640 + px);
                    e.data = v;
                end
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_clear(input logic [7:0] color, input int total);
        exp_t e;
        for (int k = 1; k <= total + 1; k++) begin
            e = '0;
            e.first = (k == 1);
            e.done  = (k == total + 1);
            if (k <= total) begin
                e.we   = 1'b1;
                e.addr = 19'(k - 1);
                e.data = color;
            end
            exp_q.push_back(e);
        end
    endfunction

    // Per-cycle compare against the expectation stream; idle when the stream is empty.
    exp_t e;
    logic idle, want_ready, bad;
    int   cyc, wr, fa, la, r0, rn, e3n;
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                idle = 1'b0;
            end else begin
                e = '0;
                idle = 1'b1;
            end
            want_ready = idle ? 1'b1 : e.done;
            bad = (bus.fb_we !== e.we) || (bus.cmd_ready !== want_ready) ||
                  (bus.busy !== ~want_ready) || (bus.done !== e.done) ||
                  (e.we && ((bus.fb_wraddress !== e.addr) || (bus.fb_data !== e.data))) ||
                  (e.rom_v && (bus.spr_rom_addr !== e.rom_addr));
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got we=%b rdy=%b busy=%b done=%b addr=%0d data=%h rom=%0d, want we=%b rdy=%b done=%b addr=%0d data=%h rom=%0d(%b)",
                         $time, bus.fb_we, bus.cmd_ready, bus.busy, bus.done, bus.fb_wraddress,
                         bus.fb_data, bus.spr_rom_addr, e.we, want_ready, e.done, e.addr,
                         e.data, e.rom_addr, e.rom_v);
            end
            if (!idle) begin
                if (e.first) begin
                    cyc = 0; wr = 0; fa = -1; la = -1; r0 = -1; rn = -1; e3n = 0;
                end
                cyc++;
                if (bus.fb_we === 1'b1) begin
                    wr++;
                    if (fa < 0) fa = int'(bus.fb_wraddress);
                    la = int'(bus.fb_wraddress);
                    if (bus.fb_data == E3) e3n++;
                end
                if (cyc == 1) r0 = int'(bus.spr_rom_addr);
                if (cyc == N) rn = int'(bus.spr_rom_addr);
                if (e.done) begin
                    st_wr.push_back(wr);
                    st_fa.push_back(fa);
                    st_la.push_back(la);
                    st_done.push_back(bus.done === 1'b1 ? cyc : -1);
                    st_r0.push_back(r0);
                    st_rn.push_back(rn);
                    st_e3.push_back(e3n);
                end
            end
        end
    end

    task automatic take_stats(input string tag);
        check({tag, "_stats_present"}, (st_wr.size() > 0) ? 1 : 0, 1);
        if (st_wr.size() > 0) begin
            g_wr = st_wr.pop_front();  g_fa = st_fa.pop_front();  g_la = st_la.pop_front();
            g_done = st_done.pop_front(); g_r0 = st_r0.pop_front(); g_rn = st_rn.pop_front();
            g_e3 = st_e3.pop_front();
        end else begin
            g_wr = -9; g_fa = -9; g_la = -9; g_done = -9; g_r0 = -9; g_rn = -9; g_e3 = -9;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget && exp_q.size() != 0; k++) begin
            @(posedge Clk); #1;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: got %0d pending cycles, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    int'(bus.fb_we), 0);
        check({tag, "_ready"}, int'(bus.cmd_ready), 1);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_done"},  int'(bus.done), 0);
        check({tag, "_data"},  int'(bus.fb_data), 0);
        check({tag, "_addr"},  int'(bus.fb_wraddress), 0);
        check({tag, "_rom"},   int'(bus.spr_rom_addr), 0);
        check({tag, "_state"}, int'(dbg_state), 0);
    endtask

    task automatic blit(input int id, input int x, input int y);
        check("blit_ready_before", int'(bus.cmd_ready), 1);
        bus.cmd_clear     = 1'b0;
        bus.cmd_sprite_id = 4'(id);
        bus.cmd_x         = 11'(x);
        bus.cmd_y         = 11'(y);
        bus.cmd_valid     = 1'b1;
        @(posedge Clk); #1;
        push_blit(id, x, y);
        bus.cmd_valid = 1'b0;
        wait_idle(3000);
    endtask

    initial begin
        int swr, sdone, k;
        logic want_we, want_rdy, want_dn;

        for (int i = 0; i < 16384; i++) begin
            rom[i] = 8'(i * 7 + 3);
            if (rom[i] == E3) rom[i] = 8'h00;
        end
        for (int p = 0; p < N; p++) begin
            rom[3 * N + p] = 8'h55;
            rom[5 * N + p] = (8'(p) == E3) ? 8'h01 : 8'(p);
            rom[6 * N + p] = (((p / 32) + (p % 32)) % 2 == 1) ? 8'hFF : E3;
        end
        bus.cmd_valid = 1'b0;  bus.cmd_clear = 1'b0;  bus.cmd_x = '0;  bus.cmd_y = '0;
        bus.cmd_sprite_id = '0; bus.cmd_color = '0;
        sbus.cmd_valid = 1'b0; sbus.cmd_clear = 1'b0; sbus.cmd_x = '0; sbus.cmd_y = '0;
        sbus.cmd_sprite_id = '0; sbus.cmd_color = '0;

        repeat (2) @(posedge Clk); #1;
        check_reset_vals("por");
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Full CLEAR on a 640x4 screen.
        sbus.cmd_clear = 1'b1;
        sbus.cmd_color = 8'h1C;
        sbus.cmd_valid = 1'b1;
        @(posedge Clk); #1;
        sbus.cmd_valid = 1'b0;
        swr = 0; sdone = -1;
        for (k = 1; k <= 2563; k++) begin
            want_we  = (k <= 2560);
            want_rdy = (k >= 2561);
            want_dn  = (k == 2561);
            vectors++;
            if ((sbus.fb_we !== want_we) || (sbus.cmd_ready !== want_rdy) ||
                (sbus.done !== want_dn) ||
                (want_we && ((sbus.fb_wraddress !== 19'(k - 1)) || (sbus.fb_data !== 8'h1C)))) begin
                miscompares++;
                $display("FAIL sclr cycle %0d: got we=%b rdy=%b done=%b addr=%0d data=%h, want we=%b rdy=%b done=%b addr=%0d data=1c",
                         k, sbus.fb_we, sbus.cmd_ready, sbus.done, sbus.fb_wraddress,
                         sbus.fb_data, want_we, want_rdy, want_dn, k - 1);
            end
            if (sbus.fb_we === 1'b1) swr++;
            if (sbus.done === 1'b1 && sdone < 0) sdone = k;
            @(posedge Clk); #1;
        end
        check("sclr_writes", swr, 2560);
        check("sclr_done_cycle", sdone, 2561);

        blit(3, 100, 50);
        take_stats("b3");
        check("b3_writes", g_wr, 1024);
        check("b3_first_addr", g_fa, 32100);
        check("b3_last_addr", g_la, 51971);
        check("b3_done_cycle", g_done, 1027);
        check("b3_rom_first", g_r0, 3072);
        check("b3_rom_last", g_rn, 4095);

        blit(5, -16, 470);
        take_stats("clip");
        check("clip_writes", g_wr, 160);
        check("clip_first_addr", g_fa, 300800);
        check("clip_done_cycle", g_done, 1027);

        blit(6, 10, 10);
        take_stats("chk");
        check("chk_writes", g_wr, 512);
        check("chk_e3_writes", g_e3, 0);

        blit(6, 700, 10);
        take_stats("off");
        check("off_writes", g_wr, 0);
        check("off_done_cycle", g_done, 1027);

        // CLEAR interrupted by reset at address 1000.
        bus.cmd_clear = 1'b1;
        bus.cmd_color = 8'h1C;
        bus.cmd_valid = 1'b1;
        @(posedge Clk); #1;
        push_clear(8'h1C, 307200);
        bus.cmd_valid = 1'b0;
        repeat (1000) begin
            @(posedge Clk); #1;
        end
        check("clr_addr_1001", int'(bus.fb_wraddress), 1000);
        check("clr_we_1001", int'(bus.fb_we), 1);
        #1 Reset_n = 1'b0;
        exp_q.delete();
        #1 check_reset_vals("mid");
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("post_rst_ready", int'(bus.cmd_ready), 1);
        blit(5, 0, 0);
        take_stats("after");
        check("after_writes", g_wr, 1024);
        check("after_first_addr", g_fa, 0);
        check("after_last_addr", g_la, 19871);
        check("after_done_cycle", g_done, 1027);

        // cmd_valid held with fields changing; second command taken on the done edge.
        bus.cmd_clear     = 1'b0;
        bus.cmd_sprite_id = 4'd5;
        bus.cmd_x         = 11'(600);
        bus.cmd_y         = 11'(460);
        bus.cmd_valid     = 1'b1;
        @(posedge Clk); #1;
        push_blit(5, 600, 460);
        repeat (5) begin
            @(posedge Clk); #1;
        end
        bus.cmd_sprite_id = 4'd3;
        bus.cmd_x         = 11'(1);
        bus.cmd_y         = 11'(1);
        bus.cmd_color     = 8'hAA;
        repeat (300) begin
            @(posedge Clk); #1;
        end
        bus.cmd_sprite_id = 4'd6;
        bus.cmd_x         = 11'(-5);
        bus.cmd_y         = 11'(-3);
        for (k = 0; k < 2000 && bus.cmd_ready !== 1'b1; k++) begin
            @(posedge Clk); #1;
        end
        check("b2b_ready_seen", int'(bus.cmd_ready), 1);
        @(posedge Clk); #1;
        push_blit(6, -5, -3);
        bus.cmd_valid = 1'b0;
        wait_idle(3000);
        take_stats("b2b_a");
        check("b2b_a_writes", g_wr, 640);
        check("b2b_a_first_addr", g_fa, 295000);
        check("b2b_a_done_cycle", g_done, 1027);
        take_stats("b2b_b");
        check("b2b_b_writes", g_wr, 391);
        check("b2b_b_first_addr", g_fa, 1);
        check("b2b_b_done_cycle", g_done, 1027);

        repeat (3) @(posedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
